uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 132 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter, with a small
// controller that hands one byte at a time to the transmitter and waits
// for it to finish before moving to the next byte.
//
// Handshakes:
// - Producer side: a byte is accepted at a rising edge when wr_en=1 and
//   full=0. A write while full is dropped and sets the sticky overflow flag.
// - Transmitter side: tx_data is valid whenever load=1. load is a one-cycle
//   start pulse. The transmitter acknowledges by raising tx_busy and
//   signals completion by dropping it. If tx_busy never rises within
//   ACK_TIMEOUT cycles, the byte is treated as sent and is not retried.
module uart_tx_feeder #(
  parameter int DEPTH       = 8,
  parameter int GAP         = 23,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     load,
  output logic [2:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // With a zero gap the controller returns straight to IDLE after a byte.
  localparam state_t AFTER_TX = (GAP == 0) ? ST_IDLE : ST_GAP;

  state_t state, state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic          push, pop;

  // Flags come from the registered count only, so a pop at the same edge
  // never makes room for a write to a full FIFO.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push      = wr_en && !full;
  assign pop       = (state == ST_IDLE) && !empty;
  assign state_dbg = state;

  // FIFO storage; no reset needed, contents are only read when count says so.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Controller next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (!empty) state_next = ST_LOAD;
      ST_LOAD:      state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)              state_next = ST_WAIT_DONE;
        else if (tmo_cnt == '0)   state_next = AFTER_TX;
      end
      ST_WAIT_DONE: if (!tx_busy) state_next = AFTER_TX;
      ST_GAP:       if (gap_cnt <= GW'(1)) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Controller registers: state, load pulse, output byte and the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      load    <= 1'b0;
      tx_data <= 8'h00;
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_next;
      load  <= (state_next == ST_LOAD);
      if (pop) tx_data <= mem[rd_ptr];
      // WAIT_BUSY lasts at most ACK_TIMEOUT cycles: counter runs ACK_TIMEOUT-1..0.
      if (state == ST_LOAD) begin
        tmo_cnt <= TW'(ACK_TIMEOUT - 1);
      end else if (state == ST_WAIT_BUSY && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      // GAP lasts exactly GAP cycles: counter reaches 0 as the state leaves.
      if (state != ST_GAP && state_next == ST_GAP) begin
        gap_cnt <= GW'(GAP);
      end else if (state == ST_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a transmitter model drives
// tx_busy, a monitor checks every load pulse against the expected queue,
// and scenario tasks check FIFO state and controller timing.
module tb_uart_tx_feeder;

  localparam int DEPTH       = 8;
  localparam int GAP         = 23;
  localparam int ACK_TIMEOUT = 4;
  localparam int BUSY_LEN    = 230;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       full, empty, overflow, load;
  logic [3:0] count;
  logic [7:0] tx_data;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  logic [7:0] exp_q[$];

  // 0: tx_busy tied low, 1: model transmitter, 2: tx_busy held high
  int busy_mode = 1;
  int busy_left = 0;
  bit pend = 1'b0;
  bit load_prev = 1'b0;

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP(GAP), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_busy(tx_busy), .tx_data(tx_data), .load(load), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // transmitter model: busy rises one cycle after load, stays up BUSY_LEN cycles
  always @(negedge clk) begin
    case (busy_mode)
      0: begin tx_busy = 1'b0; pend = 1'b0; busy_left = 0; end
      2: begin tx_busy = 1'b1; pend = 1'b0; busy_left = 0; end
      default: begin
        if (busy_left != 0) busy_left--;
        if (pend) begin busy_left = BUSY_LEN; pend = 1'b0; end
        if (load) pend = 1'b1;
        tx_busy = (busy_left != 0);
      end
    endcase
  end

  // scoreboard monitor: every load pulse must present the next expected byte
  always @(posedge clk) begin
    logic [7:0] exp_b;
    #2;
    if (load) begin
      load_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected tx_data=%h exp=none", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          errors++;
          $display("FAIL load_data got=%h exp=%h", tx_data, exp_b);
        end
      end
      checks++;
      if (load_prev) begin
        errors++;
        $display("FAIL load_double got=1 exp=0");
      end
    end
    load_prev = load;
  end

  // driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [7:0] b, input bit accept);
    wr_en = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    step;
    wr_en = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    wr_en = 1'b0;
    step;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget,
                            input string name, output int n);
    n = 0;
    while (state_dbg !== target && n < budget) begin
      step;
      n++;
    end
    checks++;
    if (state_dbg !== target) begin
      errors++;
      $display("FAIL %s_timeout state=%0d exp=%0d", name, state_dbg, target);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
    step; step;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags empty=%b full=%b exp=1/0", empty, full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    checks++; if (load !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_out load=%b tx_data=%h exp=0/00", load, tx_data); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    rst = 1'b0; wr_en = 1'b0;
    step;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_write_ignored count=%0d exp=0", count); end
  endtask

  task automatic test_single;
    int n;
    busy_mode = 1;
    drive_write(8'h01, 1'b1);
    checks++; if (count !== 4'd1 || load !== 1'b0) begin errors++; $display("FAIL single_queued count=%0d load=%b exp=1/0", count, load); end
    step;
    checks++; if (load !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL single_latency load=%b tx_data=%h exp=1/01", load, tx_data); end
    checks++; if (count !== 4'd0 || state_dbg !== S_LOAD) begin errors++; $display("FAIL single_pop count=%0d state=%0d exp=0/%0d", count, state_dbg, S_LOAD); end
    wait_state(S_WAIT_DONE, 10, "single_wait_done", n);
    wait_state(S_GAP, 400, "single_gap", n);
    checks++; if (n !== BUSY_LEN) begin errors++; $display("FAIL single_busy_len got=%0d exp=%0d", n, BUSY_LEN); end
    wait_state(S_IDLE, 100, "single_idle", n);
    checks++; if (n !== GAP) begin errors++; $display("FAIL single_gap_len got=%0d exp=%0d", n, GAP); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_drained left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_burst;
    int n;
    busy_mode = 1;
    drive_write(8'h31, 1'b1);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL burst_count0 got=%0d exp=1", count); end
    drive_write(8'h32, 1'b1);
    checks++; if (count !== 4'd1 || state_dbg !== S_LOAD) begin errors++; $display("FAIL burst_count1 count=%0d state=%0d exp=1/%0d", count, state_dbg, S_LOAD); end
    drive_write(8'h33, 1'b1);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL burst_count2 got=%0d exp=2", count); end
    for (int i = 0; i < 3; i++) begin
      wait_state(S_GAP, 400, "burst_gap", n);
      wait_state(S_IDLE, 100, "burst_idle", n);
      checks++; if (n !== GAP) begin errors++; $display("FAIL burst_gap_len got=%0d exp=%0d", n, GAP); end
      step;
      if (i < 2) begin
        checks++; if (state_dbg !== S_LOAD || count !== 4'(1 - i)) begin errors++; $display("FAIL burst_next state=%0d count=%0d exp=%0d/%0d", state_dbg, count, S_LOAD, 1 - i); end
      end else begin
        checks++; if (state_dbg !== S_IDLE || count !== 4'd0) begin errors++; $display("FAIL burst_end state=%0d count=%0d exp=%0d/0", state_dbg, count, S_IDLE); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_drained left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_no_ack;
    int n;
    int lc;
    busy_mode = 0;
    drive_write(8'hA5, 1'b1);
    step;
    checks++; if (load !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL noack_load load=%b tx_data=%h exp=1/a5", load, tx_data); end
    step;
    n = 0;
    while (state_dbg === S_WAIT_BUSY && n < 20) begin
      step;
      n++;
    end
    checks++; if (n !== ACK_TIMEOUT || state_dbg !== S_GAP) begin errors++; $display("FAIL noack_timeout cycles=%0d state=%0d exp=%0d/%0d", n, state_dbg, ACK_TIMEOUT, S_GAP); end
    wait_state(S_IDLE, 100, "noack_idle", n);
    checks++; if (n !== GAP) begin errors++; $display("FAIL noack_gap_len got=%0d exp=%0d", n, GAP); end
    lc = load_cnt;
    repeat (10) step;
    checks++; if (load_cnt !== lc) begin errors++; $display("FAIL noack_reload loads=%0d exp=%0d", load_cnt, lc); end
  endtask

  task automatic test_overflow;
    int n;
    busy_mode = 2;
    do_reset;
    drive_write(8'h40, 1'b1);
    wait_state(S_WAIT_DONE, 10, "ovf_wait_done", n);
    for (int i = 0; i < 9; i++) drive_write(8'h41 + 8'(i), (i < 8));
    checks++; if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL ovf_full count=%0d full=%b empty=%b exp=8/1/0", count, full, empty); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    busy_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      step;
      n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain left=%0d exp=0", exp_q.size()); end
    wait_state(S_GAP, 400, "ovf_gap", n);
    wait_state(S_IDLE, 100, "ovf_idle", n);
    repeat (30) step;
    checks++; if (tx_data !== 8'h48 || count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL ovf_end tx_data=%h count=%0d empty=%b exp=48/0/1", tx_data, count, empty); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_simultaneous;
    int n;
    busy_mode = 2;
    do_reset;
    drive_write(8'h60, 1'b1);
    wait_state(S_WAIT_DONE, 10, "sim_wait_done", n);
    for (int i = 0; i < 8; i++) drive_write(8'h61 + 8'(i), 1'b1);
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL sim_full full=%b overflow=%b exp=1/0", full, overflow); end
    busy_mode = 0;
    wait_state(S_GAP, 10, "sim_gap", n);
    wait_state(S_IDLE, 100, "sim_idle", n);
    drive_write(8'hEE, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== 4'd7 || state_dbg !== S_LOAD) begin errors++; $display("FAIL sim_full_pop overflow=%b count=%0d state=%0d exp=1/7/%0d", overflow, count, state_dbg, S_LOAD); end
    n = 0;
    while (!(state_dbg === S_IDLE && count === 4'd3) && n < 1000) begin
      step;
      n++;
    end
    checks++; if (state_dbg !== S_IDLE || count !== 4'd3) begin errors++; $display("FAIL sim_reach3 state=%0d count=%0d exp=%0d/3", state_dbg, count, S_IDLE); end
    drive_write(8'h5A, 1'b1);
    checks++; if (count !== 4'd3 || state_dbg !== S_LOAD) begin errors++; $display("FAIL sim_pop_write count=%0d state=%0d exp=3/%0d", count, state_dbg, S_LOAD); end
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      step;
      n++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sim_drain left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int n;
    int lc;
    busy_mode = 2;
    do_reset;
    drive_write(8'h70, 1'b1);
    wait_state(S_WAIT_DONE, 10, "rmid_wait_done", n);
    for (int i = 0; i < 4; i++) drive_write(8'h71 + 8'(i), 1'b1);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL rmid_count got=%0d exp=4", count); end
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    step;
    rst = 1'b0; wr_en = 1'b0;
    exp_q.delete();
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_flush count=%0d empty=%b exp=0/1", count, empty); end
    checks++; if (load !== 1'b0 || tx_data !== 8'h00 || state_dbg !== S_IDLE) begin errors++; $display("FAIL rmid_out load=%b tx_data=%h state=%0d exp=0/00/%0d", load, tx_data, state_dbg, S_IDLE); end
    busy_mode = 1;
    lc = load_cnt;
    repeat (50) step;
    checks++; if (load_cnt !== lc || count !== 4'd0) begin errors++; $display("FAIL rmid_quiet loads=%0d count=%0d exp=%0d/0", load_cnt, count, lc); end
    // reset while the load pulse is high
    drive_write(8'h80, 1'b1);
    step;
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL rload_pulse got=%b exp=1", load); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++; if (load !== 1'b0 || state_dbg !== S_IDLE || tx_data !== 8'h00) begin errors++; $display("FAIL rload_out load=%b state=%0d tx_data=%h exp=0/%0d/00", load, state_dbg, tx_data, S_IDLE); end
    repeat (5) step;
  endtask

  // sequence and final report
  initial begin
    test_reset;
    test_single;
    test_burst;
    test_no_ack;
    test_overflow;
    test_simultaneous;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
